// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants and the ARP receive FSM state type.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE   = 8'h55;
  localparam logic [7:0]  ETH_SFD        = 8'hD5;
  localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;

  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN       = 8'd6;
  localparam logic [7:0]  ARP_PLEN       = 8'd4;
  localparam logic [15:0] ARP_OP_REQ     = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;

  localparam int unsigned ETH_HEAD_LEN   = 14;
  localparam int unsigned ARP_LEN        = 28;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StEthHead,
    StArpData,
    StRxEnd
  } arp_rx_state_t;

endpackage

// File: rtl/arp_rx_if.sv
// GMII receive byte stream in, parsed ARP peer information out.
interface arp_rx_if;

  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic        arp_rx_done;
  logic        arp_rx_op;
  logic [47:0] src_mac;
  logic [31:0] src_ip;

  modport master (
    output gmii_rx_dv, gmii_rxd,
    input  arp_rx_done, arp_rx_op, src_mac, src_ip
  );

  modport slave (
    input  gmii_rx_dv, gmii_rxd,
    output arp_rx_done, arp_rx_op, src_mac, src_ip
  );

endinterface

// File: rtl/arp_rx.sv
// GMII ARP receive parser: strips preamble/SFD, checks Ethernet and ARP headers,
// filters on board MAC/IP and reports the sender of each accepted request/reply.
module arp_rx
  import eth_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input logic   clk,
  input logic   rst_n,
  arp_rx_if.slave rx
);

  arp_rx_state_t state_q;
  logic [4:0]    cnt_q;
  logic          dmac_not_board_q;
  logic          dmac_not_bcast_q;
  logic          op_req_q;
  logic [47:0]   mac_sh_q;
  logic [31:0]   ip_sh_q;
  logic          done_q;
  logic          op_q;
  logic [47:0]   src_mac_q;
  logic [31:0]   src_ip_q;

  logic [7:0]  rxd;
  logic        dv;
  logic [47:0] mac_shifted;
  logic [31:0] ip_shifted;
  logic [4:0]  ip_idx;
  logic [7:0]  arp_exp;
  logic        arp_chk;
  logic        op_ok;

  assign rxd = rx.gmii_rxd;
  assign dv  = rx.gmii_rx_dv;

  // Expected byte of each fixed ARP field at the current index; unchecked bytes leave arp_chk low.
  always_comb begin
    ip_idx      = cnt_q - 5'd24;
    mac_shifted = BOARD_MAC << {cnt_q, 3'b000};
    ip_shifted  = BOARD_IP << {ip_idx, 3'b000};
    op_ok       = (rxd == ARP_OP_REQ[7:0]) || (rxd == ARP_OP_REPLY[7:0]);
    arp_exp     = 8'h00;
    arp_chk     = 1'b0;
    case (cnt_q)
      5'd0:  begin arp_exp = ARP_HTYPE_ETH[15:8];  arp_chk = 1'b1; end
      5'd1:  begin arp_exp = ARP_HTYPE_ETH[7:0];   arp_chk = 1'b1; end
      5'd2:  begin arp_exp = ARP_PTYPE_IPV4[15:8]; arp_chk = 1'b1; end
      5'd3:  begin arp_exp = ARP_PTYPE_IPV4[7:0];  arp_chk = 1'b1; end
      5'd4:  begin arp_exp = ARP_HLEN;             arp_chk = 1'b1; end
      5'd5:  begin arp_exp = ARP_PLEN;             arp_chk = 1'b1; end
      5'd6:  begin arp_exp = ARP_OP_REQ[15:8];     arp_chk = 1'b1; end
      5'd24, 5'd25, 5'd26, 5'd27: begin
        arp_exp = ip_shifted[31:24];
        arp_chk = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      dmac_not_board_q <= 1'b0;
      dmac_not_bcast_q <= 1'b0;
      op_req_q         <= 1'b0;
      mac_sh_q         <= '0;
      ip_sh_q          <= '0;
      done_q           <= 1'b0;
      op_q             <= 1'b0;
      src_mac_q        <= '0;
      src_ip_q         <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (dv) begin
            if (rxd == ETH_PREAMBLE) begin
              state_q <= StPreamble;
              cnt_q   <= 5'd1;
            end else begin
              state_q <= StRxEnd;
            end
          end
        end
        StPreamble: begin
          if (!dv) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (rxd == ETH_PREAMBLE && cnt_q < 5'd7) begin
            cnt_q <= cnt_q + 5'd1;
          end else if (rxd == ETH_SFD && cnt_q == 5'd7) begin
            state_q          <= StEthHead;
            cnt_q            <= '0;
            dmac_not_board_q <= 1'b0;
            dmac_not_bcast_q <= 1'b0;
          end else begin
            state_q <= StRxEnd;
            cnt_q   <= '0;
          end
        end
        StEthHead: begin
          if (!dv) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q < 5'd6) begin
              if (rxd != mac_shifted[47:40]) dmac_not_board_q <= 1'b1;
              if (rxd != 8'hFF)              dmac_not_bcast_q <= 1'b1;
            end
            if (cnt_q == 5'd12 && rxd != ETH_TYPE_ARP[15:8]) begin
              state_q <= StRxEnd;
              cnt_q   <= '0;
            end else if (cnt_q == 5'(ETH_HEAD_LEN - 1)) begin
              cnt_q <= '0;
              // Destination must fully match one of the two accepted addresses.
              if (rxd == ETH_TYPE_ARP[7:0] && !(dmac_not_board_q && dmac_not_bcast_q)) begin
                state_q <= StArpData;
              end else begin
                state_q <= StRxEnd;
              end
            end
          end
        end
        StArpData: begin
          if (!dv) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd7) op_req_q <= (rxd == ARP_OP_REQ[7:0]);
            if (cnt_q >= 5'd8 && cnt_q <= 5'd13) mac_sh_q <= {mac_sh_q[39:0], rxd};
            if (cnt_q >= 5'd14 && cnt_q <= 5'd17) ip_sh_q <= {ip_sh_q[23:0], rxd};
            if ((arp_chk && rxd != arp_exp) || (cnt_q == 5'd7 && !op_ok)) begin
              state_q <= StRxEnd;
              cnt_q   <= '0;
            end else if (cnt_q == 5'(ARP_LEN - 1)) begin
              state_q   <= StRxEnd;
              cnt_q     <= '0;
              done_q    <= 1'b1;
              op_q      <= op_req_q;
              src_mac_q <= mac_sh_q;
              src_ip_q  <= ip_sh_q;
            end
          end
        end
        StRxEnd: begin
          if (!dv) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rx.arp_rx_done = done_q;
  assign rx.arp_rx_op   = op_q;
  assign rx.src_mac     = src_mac_q;
  assign rx.src_ip      = src_ip_q;

endmodule

// File: tb/tb_arp_rx.sv
// Self-checking bench for arp_rx: directed frames plus randomized frames against a frame-level model.
module tb_arp_rx;

  localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] IP  = 32'hC0A8010A;
  localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arp_rx_if bus ();

  arp_rx #(.BOARD_MAC(MAC), .BOARD_IP(IP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (bus)
  );

  logic [7:0]  frm[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          done_seen = 0;
  int          acc_exp = 0;
  bit          cmp_en = 1'b0;
  logic        exp_done = 1'b0;
  logic        exp_op = 1'b0;
  logic [47:0] exp_mac = '0;
  logic [31:0] exp_ip = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act !== req) $display("FAIL %s: got %h, required %h", name, act, req);
    else pass_cnt++;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("done", 64'(bus.arp_rx_done), 64'(exp_done));
      chk("op", 64'(bus.arp_rx_op), 64'(exp_op));
      chk("src_mac", 64'(bus.src_mac), 64'(exp_mac));
      chk("src_ip", 64'(bus.src_ip), 64'(exp_ip));
      if (bus.arp_rx_done === 1'b1) done_seen++;
    end
  end

  function automatic logic [7:0] bt(input logic [47:0] v, input int k);
    return v[47-8*k -: 8];
  endfunction

  task automatic build(input logic [47:0] dmac, input logic [15:0] etype, input logic [15:0] op,
                       input logic [47:0] smac, input logic [31:0] sip, input logic [31:0] tip,
                       input int pad);
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int k = 0; k < 6; k++) frm.push_back(bt(dmac, k));
    for (int k = 0; k < 6; k++) frm.push_back(8'($urandom));
    frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h01); frm.push_back(8'h08); frm.push_back(8'h00);
    frm.push_back(8'h06); frm.push_back(8'h04);
    frm.push_back(op[15:8]); frm.push_back(op[7:0]);
    for (int k = 0; k < 6; k++) frm.push_back(bt(smac, k));
    for (int k = 0; k < 4; k++) frm.push_back(bt({sip, 16'h0}, k));
    for (int k = 0; k < 6; k++) frm.push_back(8'($urandom));
    for (int k = 0; k < 4; k++) frm.push_back(bt({tip, 16'h0}, k));
    for (int k = 0; k < pad; k++) frm.push_back(8'($urandom));
  endtask

  // Frame-level acceptance rule on the bytes seen from offset b, with n bytes sent in total.
  function automatic bit frame_ok(input int b, input int n);
    bit bc = 1'b1;
    bit uc = 1'b1;
    if (n - b < 50) return 1'b0;
    for (int k = 0; k < 7; k++) if (frm[b+k] != 8'h55) return 1'b0;
    if (frm[b+7] != 8'hD5) return 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (frm[b+8+k] != 8'hFF) bc = 1'b0;
      if (frm[b+8+k] != bt(MAC, k)) uc = 1'b0;
    end
    if (!(bc || uc)) return 1'b0;
    if ({frm[b+20], frm[b+21]} != 16'h0806) return 1'b0;
    if ({frm[b+22], frm[b+23], frm[b+24], frm[b+25]} != 32'h0001_0800) return 1'b0;
    if ({frm[b+26], frm[b+27], frm[b+28]} != 24'h060400) return 1'b0;
    if (frm[b+29] != 8'h01 && frm[b+29] != 8'h02) return 1'b0;
    if ({frm[b+46], frm[b+47], frm[b+48], frm[b+49]} != IP) return 1'b0;
    return 1'b1;
  endfunction

  task automatic idle(input int k);
    repeat (k) begin
      bus.gmii_rx_dv = 1'b0;
      bus.gmii_rxd   = 8'($urandom);
      @(posedge clk); #1;
      exp_done = 1'b0;
    end
  endtask

  // Sends the first n bytes of frm; rst_at >= 0 pulses reset just before that byte.
  task automatic send(input int n, input int rst_at);
    int b = 0;
    bit ok;
    ok = frame_ok(0, n);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        exp_done = 1'b0; exp_op = 1'b0; exp_mac = '0; exp_ip = '0;
        #1 rst_n = 1'b1;
        b  = i;
        ok = frame_ok(i, n);
      end
      bus.gmii_rx_dv = 1'b1;
      bus.gmii_rxd   = frm[i];
      @(posedge clk); #1;
      exp_done = 1'b0;
      if (ok && i - b == 49) begin
        exp_done = 1'b1;
        exp_op   = (frm[b+29] == 8'h01);
        exp_mac  = {frm[b+30], frm[b+31], frm[b+32], frm[b+33], frm[b+34], frm[b+35]};
        exp_ip   = {frm[b+36], frm[b+37], frm[b+38], frm[b+39]};
        acc_exp++;
      end
    end
    idle(1);
  endtask

  initial begin
    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rxd   = 8'h00;
    repeat (2) @(posedge clk);
    #1 cmp_en = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    idle(3);

    // Broadcast request
    build(BC, 16'h0806, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80166, IP, 0);
    send(frm.size(), -1);
    chk("bcast_mac", 64'(bus.src_mac), 64'h0A0B0C0D0E0F);
    chk("bcast_ip", 64'(bus.src_ip), 64'hC0A80166);
    chk("bcast_op", 64'(bus.arp_rx_op), 64'h1);
    chk("bcast_pulses", 64'(done_seen), 64'd1);
    idle(2);

    // Unicast reply
    build(MAC, 16'h0806, 16'h0002, 48'h111213141516, 32'hC0A80167, IP, 4);
    send(frm.size(), -1);
    chk("ucast_op", 64'(bus.arp_rx_op), 64'h0);
    chk("ucast_mac", 64'(bus.src_mac), 64'h111213141516);
    idle(2);

    // Filtering: wrong target IP, wrong ethertype, wrong unicast destination
    build(BC, 16'h0806, 16'h0001, 48'hAAAAAAAAAAAA, 32'h01020304, 32'hC0A8010B, 2);
    send(frm.size(), -1);
    build(BC, 16'h0800, 16'h0001, 48'hAAAAAAAAAAAA, 32'h01020304, IP, 2);
    send(frm.size(), -1);
    build(48'h001122334456, 16'h0806, 16'h0001, 48'hAAAAAAAAAAAA, 32'h01020304, IP, 2);
    send(frm.size(), -1);
    chk("filter_mac", 64'(bus.src_mac), 64'h111213141516);
    chk("filter_ip", 64'(bus.src_ip), 64'hC0A80167);
    chk("filter_pulses", 64'(done_seen), 64'd2);

    // Truncated after sender IP byte 2, then 6x55+D5, then a valid request
    build(BC, 16'h0806, 16'h0001, 48'hBBBBBBBBBBBB, 32'h05060708, IP, 0);
    send(38, -1);
    build(BC, 16'h0806, 16'h0001, 48'hBBBBBBBBBBBB, 32'h05060708, IP, 0);
    void'(frm.pop_front());
    send(frm.size(), -1);
    chk("trunc_mac", 64'(bus.src_mac), 64'h111213141516);
    build(BC, 16'h0806, 16'h0001, 48'h212223242526, 32'hC0A80168, IP, 0);
    send(frm.size(), -1);
    chk("after_bad_mac", 64'(bus.src_mac), 64'h212223242526);

    // Back-to-back with a single idle cycle
    build(BC, 16'h0806, 16'h0001, 48'h313233343536, 32'hC0A80169, IP, 0);
    send(frm.size(), -1);
    build(MAC, 16'h0806, 16'h0002, 48'h414243444546, 32'hC0A8016A, IP, 0);
    send(frm.size(), -1);
    chk("b2b_mac", 64'(bus.src_mac), 64'h414243444546);
    chk("b2b_ip", 64'(bus.src_ip), 64'hC0A8016A);

    // Reset during ARP data, then a valid frame
    build(BC, 16'h0806, 16'h0001, 48'h515253545556, 32'hC0A8016B, IP, 3);
    send(frm.size(), 40);
    chk("rst_mac", 64'(bus.src_mac), 64'h0);
    chk("rst_op", 64'(bus.arp_rx_op), 64'h0);
    build(BC, 16'h0806, 16'h0001, 48'h616263646566, 32'hC0A8016C, IP, 0);
    send(frm.size(), -1);
    chk("post_rst_mac", 64'(bus.src_mac), 64'h616263646566);
    chk("directed_pulses", 64'(done_seen), 64'd6);

    // Randomized frames
    for (int f = 0; f < 150; f++) begin
      int r;
      int n;
      logic [47:0] dm;
      logic [15:0] op;
      r  = int'($urandom_range(0, 9));
      dm = (r < 4) ? BC : (r < 8) ? MAC : {16'h0011, 32'($urandom)};
      r  = int'($urandom_range(0, 9));
      op = (r == 0) ? 16'h0003 : (r == 1) ? 16'h0101 : (r < 6) ? 16'h0001 : 16'h0002;
      build(dm, 16'h0806, op, {16'($urandom), 32'($urandom)}, 32'($urandom),
            ($urandom_range(0, 9) == 0) ? 32'($urandom) : IP, int'($urandom_range(0, 18)));
      if ($urandom_range(0, 2) == 0) frm[$urandom_range(0, 49)] = 8'($urandom);
      n = frm.size();
      if ($urandom_range(0, 4) == 0) n = int'($urandom_range(1, frm.size() - 1));
      send(n, -1);
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    chk("total_pulses", 64'(done_seen), 64'(acc_exp));
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
